// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encoding and defaults for the pipeline stall controller
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      BUBBLE = 2'd1,
      FLUSH  = 2'd2,
      MCWAIT = 2'd3
   } stateT;

   localparam int FLUSH_CYCLES_DEF = 1;
   localparam int MC_TIMEOUT_DEF   = 64;
   localparam int STALL_W          = 16;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// rtl/pipeline_stall_ctrl_sat_counter.sv - width-parameterised saturating counter with enable
module sat_counter #(
   parameter int W = 16
) (
   input  logic         Clk,
   input  logic         Rst,
   input  logic         En,
   output logic [W-1:0] Count
);

   always_ff @(posedge Clk) begin
      if (Rst)
         Count <= '0;
      else if (En && (Count != '1))
         Count <= Count + W'(1);
   end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - 5-stage pipeline stall/flush sequencer; STALL_STATS_EN enables StallCycles
module pipeline_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
   parameter int MC_TIMEOUT   = MC_TIMEOUT_DEF,
   parameter int CNT_W        = 16
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               LoadUseReq,
   input  logic               BranchReq,
   input  logic               MultiCycleReq,
   input  logic               MultiCycleDone,
   output logic               PCWrite,
   output logic               IFIDWrite,
   output logic               IDEXWrite,
   output logic               IFIDFlush,
   output logic               IDEXFlush,
   output logic               Busy,
   output logic               TimeoutErr,
   output logic [STALL_W-1:0] StallCycles
);

   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] MC_LAST    = CNT_W'(MC_TIMEOUT - 1);

   stateT            state, stateNext;
   logic [CNT_W-1:0] cnt, cntNext;
   logic             errNext;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state      <= RUN;
         cnt        <= '0;
         TimeoutErr <= 1'b0;
      end else begin
         state      <= stateNext;
         cnt        <= cntNext;
         TimeoutErr <= errNext;
      end
   end

   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      errNext   = TimeoutErr;
      PCWrite   = 1'b1;
      IFIDWrite = 1'b1;
      IDEXWrite = 1'b1;
      IFIDFlush = 1'b0;
      IDEXFlush = 1'b0;
      Busy      = (state != RUN);

      case (state)
         RUN: begin
            if (BranchReq) begin
               stateNext = FLUSH;
               cntNext   = FLUSH_LOAD;
            end else if (LoadUseReq) begin
               stateNext = BUBBLE;
            end else if (MultiCycleReq) begin
               stateNext = MCWAIT;
               cntNext   = '0;
            end
         end
         BUBBLE: begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
            // the load-use hazard is resolved by this bubble; only a branch matters here
            if (BranchReq) begin
               stateNext = FLUSH;
               cntNext   = FLUSH_LOAD;
            end else begin
               stateNext = RUN;
            end
         end
         FLUSH: begin
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
            if (BranchReq)
               cntNext = FLUSH_LOAD;
            else if (cnt == '0)
               stateNext = RUN;
            else
               cntNext = cnt - CNT_W'(1);
         end
         MCWAIT: begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXWrite = 1'b0;
            // exiting at MC_LAST keeps the counter from ever wrapping
            if (MultiCycleDone) begin
               stateNext = RUN;
            end else if (cnt == MC_LAST) begin
               stateNext = RUN;
               errNext   = 1'b1;
            end else begin
               cntNext = cnt + CNT_W'(1);
            end
         end
         default: stateNext = RUN;
      endcase
   end

`ifdef STALL_STATS_EN
   sat_counter #(.W(STALL_W)) uStallCnt (
      .Clk   (Clk),
      .Rst   (Rst),
      .En    (~PCWrite),
      .Count (StallCycles)
   );
`else
   assign StallCycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - directed vector bench for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;

   logic Clk = 1'b0;
   logic Rst, LoadUseReq, BranchReq, MultiCycleReq, MultiCycleDone;

   logic pcW, ifidW, idexW, ifidF, idexF, busy, tErr;
   logic [15:0] stall;
   logic pcWT, ifidWT, idexWT, ifidFT, idexFT, busyT, tErrT;
   logic [15:0] stallT;

   int total = 0;
   int bad   = 0;

   always #5 Clk = ~Clk;

   pipeline_stall_ctrl #(.FLUSH_CYCLES(2), .MC_TIMEOUT(64), .CNT_W(16)) dut (
      .Clk(Clk), .Rst(Rst), .LoadUseReq(LoadUseReq), .BranchReq(BranchReq),
      .MultiCycleReq(MultiCycleReq), .MultiCycleDone(MultiCycleDone),
      .PCWrite(pcW), .IFIDWrite(ifidW), .IDEXWrite(idexW), .IFIDFlush(ifidF),
      .IDEXFlush(idexF), .Busy(busy), .TimeoutErr(tErr), .StallCycles(stall)
   );

   pipeline_stall_ctrl #(.FLUSH_CYCLES(2), .MC_TIMEOUT(8), .CNT_W(16)) dutT (
      .Clk(Clk), .Rst(Rst), .LoadUseReq(LoadUseReq), .BranchReq(BranchReq),
      .MultiCycleReq(MultiCycleReq), .MultiCycleDone(MultiCycleDone),
      .PCWrite(pcWT), .IFIDWrite(ifidWT), .IDEXWrite(idexWT), .IFIDFlush(ifidFT),
      .IDEXFlush(idexFT), .Busy(busyT), .TimeoutErr(tErrT), .StallCycles(stallT)
   );

   // output code order: {PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXFlush, Busy}
   localparam logic [5:0] O_RUN = 6'b111000;
   localparam logic [5:0] O_BUB = 6'b001011;
   localparam logic [5:0] O_FLU = 6'b111111;
   localparam logic [5:0] O_MCW = 6'b000001;

   typedef struct {
      logic       lu, br, mc, done;
      logic [5:0] exp;
   } vecT;

   vecT vecs[18];

   function automatic logic [5:0] outs();
      return {pcW, ifidW, idexW, ifidF, idexF, busy};
   endfunction

   function automatic logic [5:0] outsT();
      return {pcWT, ifidWT, idexWT, ifidFT, idexFT, busyT};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic lu, input logic br, input logic mc, input logic done);
      LoadUseReq     = lu;
      BranchReq      = br;
      MultiCycleReq  = mc;
      MultiCycleDone = done;
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic doReset();
      Rst = 1'b1;
      drive(0, 0, 0, 0);
      step();
      Rst = 1'b0;
   endtask

   task automatic setVec(input int i, input logic lu, input logic br, input logic mc,
                         input logic done, input logic [5:0] exp);
      vecs[i].lu   = lu;
      vecs[i].br   = br;
      vecs[i].mc   = mc;
      vecs[i].done = done;
      vecs[i].exp  = exp;
   endtask

   initial begin
      Rst = 1'b1;
      drive(1, 1, 1, 1);

      //          lu br mc dn  expected after sampling edge
      setVec( 0, 0, 0, 0, 0, O_RUN);
      setVec( 1, 1, 0, 0, 0, O_BUB);
      setVec( 2, 0, 0, 0, 0, O_RUN);
      setVec( 3, 1, 0, 1, 0, O_BUB);   // load-use beats multi-cycle
      setVec( 4, 1, 0, 0, 0, O_RUN);   // load-use ignored in BUBBLE
      setVec( 5, 1, 1, 0, 0, O_FLU);   // branch beats load-use
      setVec( 6, 1, 0, 1, 0, O_FLU);
      setVec( 7, 0, 0, 0, 0, O_RUN);
      setVec( 8, 0, 1, 0, 0, O_FLU);
      setVec( 9, 0, 1, 0, 0, O_FLU);   // restart flush
      setVec(10, 0, 0, 0, 0, O_FLU);
      setVec(11, 0, 0, 0, 0, O_RUN);
      setVec(12, 1, 0, 0, 0, O_BUB);
      setVec(13, 0, 1, 0, 0, O_FLU);   // bubble then branch
      setVec(14, 0, 0, 0, 0, O_FLU);
      setVec(15, 0, 0, 0, 0, O_RUN);
      setVec(16, 0, 0, 0, 1, O_RUN);   // stray done in RUN
      setVec(17, 0, 0, 0, 0, O_RUN);

      // reset held 2 cycles with every request high
      step();
      step();
      chk("reset_outs", {26'd0, outs()}, {26'd0, O_RUN});
      chk("reset_err", {31'd0, tErr}, 32'd0);
      chk("reset_stall", {16'd0, stall}, 32'd0);
      Rst = 1'b0;
      drive(0, 0, 0, 0);
      step();
      chk("post_reset_outs", {26'd0, outs()}, {26'd0, O_RUN});

      foreach (vecs[i]) begin
         drive(vecs[i].lu, vecs[i].br, vecs[i].mc, vecs[i].done);
         step();
         chk($sformatf("vec%0d", i), {26'd0, outs()}, {26'd0, vecs[i].exp});
         chk($sformatf("vec%0d_T", i), {26'd0, outsT()}, {26'd0, vecs[i].exp});
`ifndef STALL_STATS_EN
         chk($sformatf("vec%0d_stall", i), {16'd0, stall}, 32'd0);
`endif
      end

      // multi-cycle: 10 frozen cycles, branch/load-use ignored, then done
      doReset();
      drive(0, 0, 1, 0);
      step();
      chk("mc_frz1", {26'd0, outs()}, {26'd0, O_MCW});
      for (int i = 2; i <= 10; i++) begin
         drive(i == 5, (i == 3) || (i == 4), 0, 0);
         step();
         chk($sformatf("mc_frz%0d", i), {26'd0, outs()}, {26'd0, O_MCW});
      end
      drive(0, 0, 0, 1);
      step();
      chk("mc_done", {26'd0, outs()}, {26'd0, O_RUN});
      chk("mc_no_err", {31'd0, tErr}, 32'd0);
`ifdef STALL_STATS_EN
      chk("mc_stall10", {16'd0, stall}, 32'd10);
`else
      chk("mc_stall0", {16'd0, stall}, 32'd0);
`endif

      // timeout on the MC_TIMEOUT=8 instance: exactly 8 MCWAIT cycles
      doReset();
      drive(0, 0, 1, 0);
      step();
      drive(0, 0, 0, 0);
      for (int i = 1; i <= 8; i++) begin
         chk($sformatf("to_wait%0d", i), {26'd0, outsT()}, {26'd0, O_MCW});
         chk($sformatf("to_err_lo%0d", i), {31'd0, tErrT}, 32'd0);
         step();
      end
      chk("to_exit", {26'd0, outsT()}, {26'd0, O_RUN});
      chk("to_err", {31'd0, tErrT}, 32'd1);
      drive(1, 0, 0, 0);
      step();
      drive(0, 1, 0, 0);
      step();
      drive(0, 0, 0, 0);
      step();
      step();
      chk("to_err_sticky", {31'd0, tErrT}, 32'd1);
      chk("to_back_run", {26'd0, outsT()}, {26'd0, O_RUN});

      // reset in the middle of MCWAIT
      drive(0, 0, 1, 0);
      step();
      drive(0, 0, 0, 0);
      step();
      chk("mid_mcw", {26'd0, outsT()}, {26'd0, O_MCW});
      Rst = 1'b1;
      step();
      Rst = 1'b0;
      chk("mid_rst_outs", {26'd0, outsT()}, {26'd0, O_RUN});
      chk("mid_rst_err", {31'd0, tErrT}, 32'd0);
      step();
      chk("mid_rst_stay", {26'd0, outsT()}, {26'd0, O_RUN});

      // reset in the middle of FLUSH
      drive(0, 1, 0, 0);
      step();
      chk("mid_flu", {26'd0, outs()}, {26'd0, O_FLU});
      drive(0, 1, 0, 0);
      Rst = 1'b1;
      step();
      Rst = 1'b0;
      drive(0, 0, 0, 0);
      chk("mid_flu_rst", {26'd0, outs()}, {26'd0, O_RUN});

`ifdef STALL_STATS_EN
      // one bubble plus 10 MCWAIT cycles
      doReset();
      drive(1, 0, 0, 0);
      step();
      drive(0, 0, 0, 0);
      step();
      drive(0, 0, 1, 0);
      step();
      drive(0, 0, 0, 0);
      for (int i = 0; i < 9; i++) step();
      drive(0, 0, 0, 1);
      step();
      drive(0, 0, 0, 0);
      chk("stats_11", {16'd0, stall}, 32'd11);

      // hold MultiCycleReq: 64 stalled of every 65 cycles, well past 70000 stalls
      drive(0, 0, 1, 0);
      for (int i = 0; i < 72000; i++) step();
      drive(0, 0, 0, 0);
      chk("stats_sat", {16'd0, stall}, 32'h0000FFFF);
      Rst = 1'b1;
      step();
      Rst = 1'b0;
      chk("stats_rst", {16'd0, stall}, 32'd0);
`else
      chk("stats_off", {16'd0, stall}, 32'd0);
      chk("stats_off_T", {16'd0, stallT}, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Consumes the merged hazard/flush request lines produced by the pipeline's request-combining logic.
- Sequences the pipeline-register controls for the 5-stage MIPS pipeline: PC write, IF/ID write, ID/EX write, IF/ID flush and ID/EX flush.
- Handles three cases: load-use bubbles, taken-branch flushes, and multi-cycle EX operations that freeze the front end until done.
- Outputs are Moore-style. The upstream hazard logic issues requests one cycle ahead of need.

Parameters:
- FLUSH_CYCLES, 1, number of consecutive cycles IF/ID and ID/EX are flushed after a taken branch (1..7).
- MC_TIMEOUT, 64, maximum cycles spent in MCWAIT before forced exit with error (2..65535).
- CNT_W, 16, width of the internal wait/flush counter.

Ports:
- Clk  input  1  rising-edge clock
- Rst  input  1  synchronous, active-high reset
- LoadUseReq  input  1  load-use hazard: insert one bubble
- BranchReq  input  1  taken branch/jump: flush younger instructions
- MultiCycleReq  input  1  EX starts a multi-cycle op: freeze the front end
- MultiCycleDone  input  1  multi-cycle op result is ready
- PCWrite  output  1  PC register enable
- IFIDWrite  output  1  IF/ID register enable
- IDEXWrite  output  1  ID/EX register enable
- IFIDFlush  output  1  zero the IF/ID register
- IDEXFlush  output  1  zero the ID/EX register (inserts a NOP)
- Busy  output  1  state is not RUN
- TimeoutErr  output  1  sticky: MCWAIT exited by timeout
- StallCycles  output  16  stall statistics (see Optional Feature)

Behaviour:
- One clock, Clk. Reset is synchronous and active-high on Rst. Rst forces state RUN, counter 0 and TimeoutErr 0; it overrides every input, including mid-FLUSH and mid-MCWAIT.
- Requests are sampled at rising edge N. The corresponding outputs are valid during cycle N+1 (1-cycle latency).
- RUN outputs: PCWrite=1, IFIDWrite=1, IDEXWrite=1, IFIDFlush=0, IDEXFlush=0, Busy=0. These are also the reset values.
- BUBBLE outputs: PCWrite=0, IFIDWrite=0, IDEXWrite=1, IDEXFlush=1, IFIDFlush=0. Lasts exactly 1 cycle.
- FLUSH outputs: PCWrite=1, IFIDWrite=1, IDEXWrite=1, IFIDFlush=1, IDEXFlush=1. Lasts FLUSH_CYCLES cycles, counted by the counter.
- MCWAIT outputs: PCWrite=0, IFIDWrite=0, IDEXWrite=0, both flushes 0.
- Transitions out of RUN, in priority order:
  - BranchReq -> FLUSH
  - else LoadUseReq -> BUBBLE
  - else MultiCycleReq -> MCWAIT
  - else stay in RUN
- BUBBLE -> FLUSH if BranchReq, else RUN. A LoadUseReq sampled while in BUBBLE is ignored, because the hazard has already been resolved.
- FLUSH:
  - The counter is loaded with FLUSH_CYCLES-1 on entry and decremented each cycle; at 0 the state goes to RUN.
  - A BranchReq sampled while in FLUSH reloads the counter (the flush restarts).
  - LoadUseReq and MultiCycleReq are ignored in FLUSH; the instructions raising them are being squashed.
- MCWAIT:
  - The counter is loaded with 0 on entry and increments each cycle.
  - MultiCycleDone -> RUN.
  - Otherwise, when the counter reaches MC_TIMEOUT-1 -> RUN and set TimeoutErr.
  - BranchReq, LoadUseReq and MultiCycleReq are ignored, because EX is frozen.
  - MultiCycleDone in the same cycle as entry is not possible, since it is sampled only from MCWAIT.
- Simultaneous events:
  - BranchReq together with LoadUseReq -> FLUSH.
  - MultiCycleReq together with LoadUseReq -> BUBBLE. The multi-cycle op is re-requested by upstream after the bubble.
- TimeoutErr is cleared only by Rst.
- Counter width is CNT_W with no wrap. The MCWAIT exit at MC_TIMEOUT-1 guarantees the counter never overflows.

Optional Feature:
- Macro STALL_STATS_EN.
- Defined: StallCycles is a 16-bit saturating counter that increments in every cycle where PCWrite=0. It holds at 16'hFFFF and resets to 0 on Rst.
- Not defined: StallCycles is tied to 16'h0000 and no counter logic is present.
- Control behaviour is identical either way.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state encoding constants: RUN=2'd0, BUBBLE=2'd1, FLUSH=2'd2, MCWAIT=2'd3;
  - the default FLUSH_CYCLES and MC_TIMEOUT values;
  - the StallCycles width of 16.
- One sub-module, sat_counter, a width-parameterised saturating counter with enable, used for StallCycles. Everything else stays in pipeline_stall_ctrl.

Test Plan:
- Reset: hold Rst 2 cycles with all requests 1 -> PCWrite=IFIDWrite=IDEXWrite=1, flushes 0, Busy=0, TimeoutErr=0 in the first cycle after release.
- Load-use: pulse LoadUseReq at edge 5 -> cycle 6 shows PCWrite=0, IFIDWrite=0, IDEXFlush=1; cycle 7 is back in RUN.
- Branch with FLUSH_CYCLES=2: pulse BranchReq together with LoadUseReq -> 2 cycles of IFIDFlush=IDEXFlush=1, no bubble, then RUN. A second BranchReq during the first flush cycle extends the flush to 3 cycles in total.
- Multi-cycle: MultiCycleReq, then MultiCycleDone 10 cycles later -> 10 frozen cycles, then RUN; BranchReq asserted while frozen has no effect.
- Timeout with MC_TIMEOUT=8 and Done never asserted -> exactly 8 MCWAIT cycles, then RUN with TimeoutErr=1 held until Rst. Asserting Rst mid-MCWAIT returns to RUN next cycle with TimeoutErr=0.
- STALL_STATS_EN defined: 1 bubble plus 10 MCWAIT cycles -> StallCycles=11; forcing 70000 stall cycles -> StallCycles=16'hFFFF. Macro undefined -> StallCycles=0 throughout.
